// File: rtl/seq_shifter_n_bit.sv
// Multi-cycle N-bit shift unit (LSL/LSR/ASR/ROR), up to STEP bit positions per clock,
// with start/busy/done handshake and the ALU {n,z,v,c} flag nibble.
module seq_shifter_n_bit #(
    parameter int N    = 8,
    parameter int STEP = 1,
    parameter int SHW  = $clog2(N) + 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [1:0]     mode,
    input  logic [N-1:0]   in_a,
    input  logic [SHW-1:0] shift,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   out,
    output logic [3:0]     flags_n_z_v_c
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        M_LSL = 2'b00,
        M_LSR = 2'b01,
        M_ASR = 2'b10,
        M_ROR = 2'b11
    } mode_t;

    state_t         state_q, state_d;
    mode_t          mode_q, mode_d;
    logic [N-1:0]   work_q, work_d;
    logic [SHW-1:0] rem_q, rem_d;
    logic           c_q, c_d;
    logic           v_q, v_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [N-1:0]   out_q, out_d;
    logic [3:0]     flags_q, flags_d;

    logic [SHW-1:0] k;
    logic [N-1:0]   step_w;
    logic           step_c;
    logic           step_v;
    logic [SHW-1:0] step_s;

    // Effective count: LSL/LSR saturate at N+1, ASR at N, ROR wraps modulo N.
    always_comb begin
        k = shift;
        case (mode_t'(mode))
            M_LSL, M_LSR: k = (shift > SHW'(N + 1)) ? SHW'(N + 1) : shift;
            M_ASR:        k = (shift > SHW'(N)) ? SHW'(N) : shift;
            M_ROR:        k = shift % SHW'(N);
            default:      k = shift;
        endcase
    end

    // Up to STEP chained 1-bit steps; steps beyond the remaining count are skipped
    // so the result always equals k successive single-bit shifts.
    always_comb begin
        step_w = work_q;
        step_c = c_q;
        step_v = v_q;
        for (int unsigned i = 0; i < STEP; i++) begin
            if (SHW'(i) < rem_q) begin
                case (mode_q)
                    M_LSL: begin
                        step_c = step_w[N-1];
                        if (step_w[N-1] != step_w[N-2]) step_v = 1'b1;
                        step_w = {step_w[N-2:0], 1'b0};
                    end
                    M_LSR: begin
                        step_c = step_w[0];
                        step_w = {1'b0, step_w[N-1:1]};
                    end
                    M_ASR: begin
                        step_c = step_w[0];
                        step_w = {step_w[N-1], step_w[N-1:1]};
                    end
                    M_ROR: begin
                        step_w = {step_w[0], step_w[N-1:1]};
                        step_c = step_w[N-1];
                    end
                    default: step_w = step_w;
                endcase
            end
        end
        step_s = (rem_q > SHW'(STEP)) ? SHW'(STEP) : rem_q;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        work_d  = work_q;
        rem_d   = rem_q;
        c_d     = c_q;
        v_d     = v_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        out_d   = out_q;
        flags_d = flags_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = in_a;
                    mode_d  = mode_t'(mode);
                    rem_d   = k;
                    c_d     = 1'b0;
                    v_d     = 1'b0;
                    busy_d  = 1'b1;
                    state_d = (k != '0) ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                work_d = step_w;
                c_d    = step_c;
                v_d    = step_v;
                rem_d  = rem_q - step_s;
                if (rem_q == step_s) state_d = S_DONE;
            end
            S_DONE: begin
                out_d   = work_q;
                flags_d = {work_q[N-1], (work_q == '0), v_q & (mode_q == M_LSL), c_q};
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            mode_q  <= M_LSL;
            work_q  <= '0;
            rem_q   <= '0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            work_q  <= work_d;
            rem_q   <= rem_d;
            c_q     <= c_d;
            v_q     <= v_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            flags_q <= flags_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign out           = out_q;
    assign flags_n_z_v_c = flags_q;

endmodule

// File: doc/seq_shifter_n_bit.md
# seq_shifter_n_bit

Multi-cycle, parametrised shift unit for the ALU. It is the successor to the combinational N-bit left shifter and adds LSL, LSR, ASR and ROR modes. It shifts up to STEP bit positions per clock under a start/busy/done handshake and produces the same n/z/v/c flag nibble as the other ALU units. It sits beside the combinational ALU slices and is used when a single-cycle barrel shifter would be too large or too slow for wide N.

## Interface
- N, 8: data width (≥2).
- STEP, 1: maximum bit positions shifted per clock (1..N).
- SHW, $clog2(N)+1: shift-amount width; can express N.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request; accepted only when busy=0.
- mode  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR; sampled with start.
- in_a  input  N  operand; sampled with start.
- shift  input  SHW  shift amount; sampled with start.
- busy  output  1  high from the accept edge until the edge at which done rises, inclusive.
- done  output  1  one-cycle pulse; out/flags valid from then on.
- out  output  N  result; held until the next done.
- flags_n_z_v_c  output  4  {n,z,v,c}; held with out.

## Operation
- Effective count k, computed at accept:
  - LSL/LSR: k=min(shift,N+1).
  - ASR: k=min(shift,N).
  - ROR: k=shift mod N.
- FSM has three states:
  - IDLE: start accepted → capture in_a, mode and k into working registers; busy←1. Next state is SHIFT if k>0, else DONE.
  - SHIFT: shift the working register by s=min(STEP, remaining) and decrement remaining by s. Go to DONE when remaining reaches 0.
  - DONE: load out and flags from the working registers; done=1; busy←0; return to IDLE.
- Bit semantics must equal k successive 1-bit steps:
  - LSL: 0 into LSB; c = last bit out of MSB.
  - LSR: 0 into MSB; c = last bit out of LSB.
  - ASR: MSB replicated; c = last bit out of LSB.
  - ROR: LSB into MSB; c = result[N-1].
- k=0 (any mode, including ROR with shift a multiple of N): out=in_a, c=0.
- LSL/LSR k=N+1 yields out=0 and c=0 naturally.
- n = out[N-1]; z = (out==0).
- v is a sticky flag, LSL only: set if the MSB changes in any 1-bit step (signed overflow). v=0 for all other modes.
- start while busy=1 is ignored; the in-flight operation is unaffected.
- start high in DONE is ignored; the earliest accept is the cycle after done.

## Timing
- Reset (asynchronous, reset_n=0): state=IDLE, busy=0, done=0, out=0, flags=4'b0000, working registers=0.
- Reset asserted mid-operation aborts the operation immediately; nothing is produced after release.
- Latency: done is high for exactly one cycle, ceil(k/STEP)+1 rising edges after the accepting edge.
- Minimum latency is 1 edge (k=0).
- Throughput: one operation per ceil(k/STEP)+2 cycles.
- out and flags change only on the edge that raises done; they are stable at all other times.

## Test plan
- N=8, STEP=1, LSL, in_a=11110000:
  - shift=1 → out=11100000, flags=1001, done 2 edges after accept.
  - shift=3 → out=10000000, flags=1001.
  - shift=6 → out=00000000, flags=0110.
- N=8, STEP=3, ASR, in_a=10010110, shift=2 → out=11100101, flags=1001, done 2 edges after accept.
- N=8, ROR, in_a=00000011, shift=9 (k=1) → out=10000001, flags=1001. Same operand with shift=8 → out=00000011, flags=0000, done 1 edge after accept.
- N=8, STEP=1, LSR, in_a=11111111, shift=15 (k=9) → out=0, flags=0100, done 10 edges after accept, busy high throughout.
- Handshake: a second start with different operands at edges 1–3 of an in-flight LSL is ignored; the result matches the first request only.
- Reset: reset_n pulsed low mid-SHIFT → busy=0, done=0, out=0, flags=0000 asynchronously; a fresh start then completes correctly.
